// File: rtl/gpc_606_5.sv
// -----------------------------------------------------------------------------
// gpc_606_5 -- registered (6,0,6;5) generalized parallel counter
//
// Sums six weight-1 bits (src0) and six weight-4 bits (src2) into a 5-bit
// binary result: dst = popcount(src0) + 4 * popcount(src2), range 0..30.
// Intended as a leaf cell of a pipelined compressor tree.
//
// Optional build macro: GPC_606_5_INREG_EN
//   undefined : counter logic feeds the output register directly (latency 1)
//   defined   : extra input register on src0/src2/in_valid (latency 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears every stage)
//   in_valid   qualifies src0/src2 this cycle
//   src0[5:0]  column-0 bits, weight 1 each
//   src2[5:0]  column-2 bits, weight 4 each
//   out_valid  dst holds a result from a qualified input
//   dst[4:0]   binary sum; holds its last value while out_valid is low
// -----------------------------------------------------------------------------
module gpc_606_5 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] src0,
  input  logic [5:0] src2,
  output logic       out_valid,
  output logic [4:0] dst
);

  // Count ones in a 6-bit column: two full adders (3:2) on each half, then a
  // 2-bit add of the partial counts.
  function automatic logic [2:0] pop6(input logic [5:0] v);
    logic [1:0] lo_v;
    logic [1:0] hi_v;
    lo_v = {(v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]), v[0] ^ v[1] ^ v[2]};
    hi_v = {(v[3] & v[4]) | (v[3] & v[5]) | (v[4] & v[5]), v[3] ^ v[4] ^ v[5]};
    return {1'b0, lo_v} + {1'b0, hi_v};
  endfunction

  logic       cnt_valid_s;
  logic [5:0] cnt_src0_s;
  logic [5:0] cnt_src2_s;
  logic [2:0] pc0_s;
  logic [2:0] pc2_s;
  logic [4:0] sum_s;
  logic [4:0] dst_r;
  logic       out_valid_r;

`ifdef GPC_606_5_INREG_EN
  logic       in_valid_r;
  logic [5:0] src0_r;
  logic [5:0] src2_r;

  // Input capture stage; data is captured every cycle, validity tracks in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_r <= 1'b0;
      src0_r     <= 6'd0;
      src2_r     <= 6'd0;
    end else begin
      in_valid_r <= in_valid;
      src0_r     <= src0;
      src2_r     <= src2;
    end
  end

  // Counter operands come from the input register stage.
  always_comb begin
    cnt_valid_s = in_valid_r;
    cnt_src0_s  = src0_r;
    cnt_src2_s  = src2_r;
  end
`else
  // Counter operands come straight from the ports.
  always_comb begin
    cnt_valid_s = in_valid;
    cnt_src0_s  = src0;
    cnt_src2_s  = src2;
  end
`endif

  // Column counts combined: src2 count lands at bit 2 (weight 4), so the
  // low two bits of the result are just the low bits of the src0 count.
  always_comb begin
    pc0_s = pop6(cnt_src0_s);
    pc2_s = pop6(cnt_src2_s);
    sum_s = {2'b00, pc0_s} + {pc2_s, 2'b00};
  end

  // Output stage: load on valid, hold data (but drop the flag) otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_r       <= 5'd0;
      out_valid_r <= 1'b0;
    end else if (cnt_valid_s) begin
      dst_r       <= sum_s;
      out_valid_r <= 1'b1;
    end else begin
      dst_r       <= dst_r;
      out_valid_r <= 1'b0;
    end
  end

  assign dst       = dst_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_gpc_606_5.sv
// -----------------------------------------------------------------------------
// tb_gpc_606_5 -- self-checking bench for gpc_606_5.
// Expected sums are pushed to a queue when stimulus is applied and popped when
// the latency model says the DUT should present them.
// -----------------------------------------------------------------------------
module tb_gpc_606_5;

`ifdef GPC_606_5_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] src0;
  logic [5:0] src2;
  logic       out_valid;
  logic [4:0] dst;

  int         vectors;
  int         miscompares;

  logic [4:0] exp_q[$];
  logic [1:0] ov_pipe;
  logic       exp_ov;
  logic [4:0] exp_dst;

  gpc_606_5 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .src0      (src0),
    .src2      (src2),
    .out_valid (out_valid),
    .dst       (dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sum(input logic [5:0] a, input logic [5:0] b);
    int s;
    s = $countones(a) + 4 * $countones(b);
    return s[4:0];
  endfunction

  // Apply one cycle of stimulus, advance past the edge, update the model.
  task automatic drive(input logic r, input logic v, input logic [5:0] a, input logic [5:0] b);
    rst      = r;
    in_valid = v;
    src0     = a;
    src2     = b;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      ov_pipe = 2'b00;
      exp_ov  = 1'b0;
      exp_dst = 5'd0;
    end else begin
      if (v) exp_q.push_back(ref_sum(a, b));
      ov_pipe = {ov_pipe[0], v};
      exp_ov  = ov_pipe[LAT-1];
      if (exp_ov && exp_q.size() > 0) exp_dst = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 6'h3f, 6'h3f);
    drive(1'b1, 1'b1, 6'h3f, 6'h3f);
    vectors++;
    if (out_valid !== 1'b0 || dst !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_state: got ov=%b dst=%0d want ov=0 dst=0", out_valid, dst);
    end
  endtask

  task automatic test_directed();
    logic [5:0] ta[7] = '{6'h2f, 6'h3c, 6'h00, 6'h37, 6'h00, 6'h3f, 6'h3f};
    logic [5:0] tb[7] = '{6'h2b, 6'h16, 6'h2c, 6'h36, 6'h00, 6'h3f, 6'h00};
    logic [4:0] te[7] = '{5'd21, 5'd16, 5'd12, 5'd21, 5'd0, 5'd30, 5'd6};
    drive(1'b0, 1'b0, 6'h00, 6'h00);
    for (int i = 0; i < 7 + LAT; i++) begin
      if (i < 7) drive(1'b0, 1'b1, ta[i], tb[i]);
      else       drive(1'b0, 1'b0, 6'h00, 6'h00);
      if (i >= LAT - 1 && i - (LAT - 1) < 7) begin
        vectors++;
        if (out_valid !== 1'b1 || dst !== te[i-(LAT-1)]) begin
          miscompares++;
          $display("FAIL directed[%0d]: got ov=%b dst=%0d want ov=1 dst=%0d",
                   i - (LAT - 1), out_valid, dst, te[i-(LAT-1)]);
        end
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 6'h0f, 6'h1f);
    for (int i = 0; i < LAT + 3; i++) begin
      drive(1'b0, 1'b0, 6'h3f, 6'h3f);
      vectors++;
      if (out_valid !== exp_ov || dst !== exp_dst) begin
        miscompares++;
        $display("FAIL hold[%0d]: got ov=%b dst=%0d want ov=%b dst=%0d",
                 i, out_valid, dst, exp_ov, exp_dst);
      end
    end
    vectors++;
    if (out_valid !== 1'b0 || dst !== 5'd24) begin
      miscompares++;
      $display("FAIL hold_final: got ov=%b dst=%0d want ov=0 dst=24", out_valid, dst);
    end
  endtask

  task automatic test_reset_midstream();
    int wait_cnt;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 6'($urandom), 6'($urandom));
    drive(1'b1, 1'b1, 6'h3f, 6'h3f);
    vectors++;
    if (out_valid !== 1'b0 || dst !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_midstream: got ov=%b dst=%0d want ov=0 dst=0", out_valid, dst);
    end
    drive(1'b0, 1'b1, 6'h3f, 6'h3f);
    wait_cnt = 1;
    while (out_valid !== 1'b1 && wait_cnt < 8) begin
      drive(1'b0, 1'b0, 6'h00, 6'h00);
      wait_cnt++;
    end
    vectors++;
    if (wait_cnt !== LAT || dst !== 5'd30) begin
      miscompares++;
      $display("FAIL reset_release_latency: got cycles=%0d dst=%0d want cycles=%0d dst=30",
               wait_cnt, dst, LAT);
    end
    for (int i = 0; i < LAT; i++) drive(1'b0, 1'b0, 6'h00, 6'h00);
  endtask

  task automatic test_back_to_back();
    int ov_cnt;
    ov_cnt = 0;
    for (int i = 0; i < 20 + LAT; i++) begin
      if (i < 20) drive(1'b0, 1'b1, 6'($urandom), 6'($urandom));
      else        drive(1'b0, 1'b0, 6'h00, 6'h00);
      if (out_valid === 1'b1) ov_cnt++;
      vectors++;
      if (out_valid !== exp_ov || dst !== exp_dst) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got ov=%b dst=%0d want ov=%b dst=%0d",
                 i, out_valid, dst, exp_ov, exp_dst);
      end
    end
    vectors++;
    if (ov_cnt !== 20) begin
      miscompares++;
      $display("FAIL back_to_back_count: got %0d valid cycles want 20", ov_cnt);
    end
  endtask

  task automatic test_exhaustive();
    int bad;
    bad = 0;
    for (int k = 0; k < 4096 + LAT; k++) begin
      if (k < 4096) drive(1'b0, 1'b1, 6'(k), 6'(k >> 6));
      else          drive(1'b0, 1'b0, 6'h00, 6'h00);
      if (k >= LAT - 1) begin
        vectors++;
        if (out_valid !== exp_ov || dst !== exp_dst) begin
          miscompares++;
          bad++;
          if (bad < 10)
            $display("FAIL exhaustive[%0d]: got ov=%b dst=%0d want ov=%b dst=%0d",
                     k - (LAT - 1), out_valid, dst, exp_ov, exp_dst);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ov_pipe     = 2'b00;
    exp_ov      = 1'b0;
    exp_dst     = 5'd0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    src0        = 6'h00;
    src2        = 6'h00;
    test_reset();
    test_directed();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
